// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, default oversampling
// ratio and counter-width helpers (also meant for a future uart_tx).
package uart_pkg;

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} uart_rx_state_t;

    localparam int UART_OVERSAMPLE = 16;

    // Bits needed to hold 0..n-1, never less than one.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Bits needed to hold 0..n (log2(n)+1), e.g. a bit counter over n bits.
    function automatic int idx_width(input int n);
        return $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/sync_nff.sv
// N-stage synchroniser for an asynchronous single-bit input.
// Flops reset to 1 so an idle-high line stays idle through reset.
module sync_nff #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic n_rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;

    // Shift the asynchronous input through the synchroniser chain.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            sync_q <= {STAGES{RST_VAL}};
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d};
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/uart_rx_16x.sv
// Oversampling UART receiver: synchronises rx, detects the start bit,
// majority-votes three mid-bit samples per bit and hands completed words
// to a ready/valid consumer. Framing errors and overruns are 1-cycle pulses.
// DATA_BITS 5..9, OVERSAMPLE even and >= 8, SYNC_STAGES >= 2.
module uart_rx_16x
    import uart_pkg::*;
#(
    parameter int DATA_BITS   = 8,
    parameter int OVERSAMPLE  = UART_OVERSAMPLE,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 en,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 valid_out,
    input  logic                 ready_in,
    output logic                 frame_err,
    output logic                 overrun
);

    localparam int TW = cnt_width(OVERSAMPLE);
    localparam int BW = idx_width(DATA_BITS);

    // Tick positions inside one bit period.
    localparam logic [TW-1:0] T_S0   = TW'(OVERSAMPLE/2 - 1);
    localparam logic [TW-1:0] T_S1   = TW'(OVERSAMPLE/2);
    localparam logic [TW-1:0] T_DEC  = TW'(OVERSAMPLE/2 + 1);
    localparam logic [TW-1:0] T_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

    logic                 rxs;
    uart_rx_state_t       state_q, state_d;
    logic [TW-1:0]        tcnt_q, tcnt_d;
    logic [BW-1:0]        bcnt_q, bcnt_d;
    logic                 s0_q, s0_d;
    logic                 s1_q, s1_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 armed_q, armed_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 ferr_q, ferr_d;
    logic                 ovr_q, ovr_d;
    logic                 word_done;
    logic                 at_dec;
    logic                 at_wrap;
    logic                 vote;

    sync_nff #(
        .STAGES  (SYNC_STAGES),
        .RST_VAL (1'b1)
    ) u_sync (
        .clk   (clk),
        .n_rst (n_rst),
        .d     (rx),
        .q     (rxs)
    );

    assign at_dec  = (tcnt_q == T_DEC);
    assign at_wrap = (tcnt_q == T_LAST);
    // The third sample is the live rxs on the decision tick.
    assign vote    = (s0_q & s1_q) | (s0_q & rxs) | (s1_q & rxs);

    // Receive FSM: start detection, bit timing, sampling and stop-bit check.
    always_comb begin
        // NOTE: every signal gets a default here so no path leaves it unassigned, which would infer a latch.
        state_d   = state_q;
        tcnt_d    = tcnt_q;
        bcnt_d    = bcnt_q;
        s0_d      = s0_q;
        s1_d      = s1_q;
        shift_d   = shift_q;
        armed_d   = armed_q | rxs;
        word_done = 1'b0;
        ferr_d    = 1'b0;

        if (tcnt_q == T_S0) s0_d = rxs;
        if (tcnt_q == T_S1) s1_d = rxs;

        if (!en) begin
            // Disabled: abort silently and require the line to be seen
            // high again before a new start bit is accepted.
            state_d = IDLE;
            tcnt_d  = '0;
            bcnt_d  = '0;
            armed_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (armed_q && !rxs) begin
                        state_d = START;
                        tcnt_d  = '0;
                    end
                end
                START: begin
                    tcnt_d = tcnt_q + 1'b1;
                    if (at_dec && vote) begin
                        state_d = IDLE;  // glitch, not a start bit
                        tcnt_d  = '0;
                    end else if (at_wrap) begin
                        state_d = DATA;
                        tcnt_d  = '0;
                        bcnt_d  = '0;
                    end
                end
                DATA: begin
                    tcnt_d = tcnt_q + 1'b1;
                    if (at_dec) shift_d[bcnt_q] = vote;
                    if (at_wrap) begin
                        tcnt_d = '0;
                        bcnt_d = bcnt_q + 1'b1;
                        if (bcnt_q == B_LAST) state_d = STOP;
                    end
                end
                STOP: begin
                    tcnt_d = tcnt_q + 1'b1;
                    if (at_dec) begin
                        // Leave mid stop bit so a back-to-back start edge is not missed.
                        tcnt_d = '0;
                        if (vote) begin
                            word_done = 1'b1;
                            state_d   = IDLE;
                        end else begin
                            ferr_d  = 1'b1;
                            state_d = BREAK;
                        end
                    end
                end
                BREAK: begin
                    if (rxs) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Output register and ready/valid handshake, independent of en.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        ovr_d   = 1'b0;
        if (word_done && (!valid_q || ready_in)) begin
            data_d  = shift_q;
            valid_d = 1'b1;
        end else if (word_done) begin
            ovr_d = 1'b1;  // register still full: drop the new word
        end else if (valid_q && ready_in) begin
            valid_d = 1'b0;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q <= IDLE;
            tcnt_q  <= '0;
            bcnt_q  <= '0;
            s0_q    <= 1'b1;
            s1_q    <= 1'b1;
            // NOTE: the shift register is reset too; it is only DATA_BITS wide and keeps data_out deterministic.
            shift_q <= '0;
            armed_q <= 1'b0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the pre-edge values.
            state_q <= state_d;
            tcnt_q  <= tcnt_d;
            bcnt_q  <= bcnt_d;
            s0_q    <= s0_d;
            s1_q    <= s1_d;
            shift_q <= shift_d;
            armed_q <= armed_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end

    assign data_out  = data_q;
    assign valid_out = valid_q;
    assign frame_err = ferr_q;
    assign overrun   = ovr_q;

endmodule

// File: tb/tb_uart_rx_16x.sv
// Scoreboard bench for uart_rx_16x: the stimulus side pushes the words a
// correct receiver must deliver; a monitor pops them on each handshake.
module tb_uart_rx_16x;

    localparam int DATA_BITS = 8;
    localparam int OS        = 16;
    localparam int SYNC      = 2;
    // rx edge to valid_out: synchroniser, one cycle to leave IDLE, start and
    // data bits, the stop-bit decision tick, then the output register.
    localparam int LAT = SYNC + 1 + (DATA_BITS + 1) * OS + OS/2 + 1 + 1;

    typedef struct {
        logic [DATA_BITS-1:0] word;
        int                   start_cyc;
    } exp_t;

    logic                 clk;
    logic                 n_rst;
    logic                 en;
    logic                 rx;
    logic [DATA_BITS-1:0] data_out;
    logic                 valid_out;
    logic                 ready_in;
    logic                 frame_err;
    logic                 overrun;

    exp_t exp_q[$];
    int   cyc       = 0;
    int   checks    = 0;
    int   failures  = 0;
    int   exp_ferr  = 0;
    int   exp_ovr   = 0;
    int   seen_ferr = 0;
    int   seen_ovr  = 0;

    logic                 valid_prev = 1'b0;
    logic                 ready_prev = 1'b0;
    logic [DATA_BITS-1:0] data_prev  = '0;

    uart_rx_16x #(
        .DATA_BITS   (DATA_BITS),
        .OVERSAMPLE  (OS),
        .SYNC_STAGES (SYNC)
    ) dut (
        .clk       (clk),
        .n_rst     (n_rst),
        .en        (en),
        .rx        (rx),
        .data_out  (data_out),
        .valid_out (valid_out),
        .ready_in  (ready_in),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b, input bit spike);
        for (int i = 0; i < OS; i++) begin
            rx = (spike && i == OS/2 + 1) ? 1'b1 : b;
            tick();
        end
    endtask

    // One full frame; a good frame is pushed as an expected word.
    task automatic send_frame(input logic [DATA_BITS-1:0] w, input logic stop_b,
                              input bit spike, input bit expect_word);
        exp_t e;
        e.word      = w;
        e.start_cyc = cyc;
        if (expect_word) exp_q.push_back(e);
        send_bit(1'b0, spike);
        for (int i = 0; i < DATA_BITS; i++) send_bit(w[i], spike);
        send_bit(stop_b, 1'b0);
        if (!stop_b) exp_ferr++;
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) tick();
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_data_out"}, data_out, 0);
        check({tag, "_valid_out"}, valid_out, 0);
        check({tag, "_frame_err"}, frame_err, 0);
        check({tag, "_overrun"}, overrun, 0);
    endtask

    // Monitor: sampled on the falling edge, away from DUT updates.
    always @(negedge clk) begin
        exp_t e;
        if (n_rst) begin
            if (valid_out && !valid_prev) begin
                if (exp_q.size() > 0) check("latency", cyc - exp_q[0].start_cyc, LAT);
                else check("unexpected_valid", valid_out, 0);
            end
            if (valid_out && ready_in) begin
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("data", data_out, e.word);
                end else begin
                    check("unexpected_word", valid_out, 0);
                end
            end
            if (valid_prev && valid_out && !ready_prev) check("data_hold", data_out, data_prev);
            if (frame_err) seen_ferr++;
            if (overrun) seen_ovr++;
            if (frame_err && overrun) check("ferr_ovr_exclusive", overrun, 0);
        end
        valid_prev = valid_out;
        ready_prev = ready_in;
        data_prev  = data_out;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        logic [DATA_BITS-1:0] w;
        bit                   bad;

        rx       = 1'b1;
        en       = 1'b1;
        ready_in = 1'b1;
        n_rst    = 1'b0;
        repeat (4) tick();
        check_outputs_zero("reset");
        n_rst = 1'b1;
        idle(20);

        // Basic frame.
        send_frame(8'hA5, 1'b1, 1'b0, 1'b1);
        idle(20);
        check("a5_delivered", exp_q.size(), 0);

        // Short glitch must not start a frame; the next frame still works.
        rx = 1'b0;
        repeat (3) tick();
        idle(40);
        send_frame(8'h5A, 1'b1, 1'b0, 1'b1);
        idle(20);

        // Bad stop bit followed by a held-low line.
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
        rx = 1'b0;
        repeat (40) tick();
        check("ferr_after_3c", seen_ferr, exp_ferr);
        idle(10);
        send_frame(8'h55, 1'b1, 1'b0, 1'b1);
        idle(20);

        // Overrun: consumer stalled across two frames.
        ready_in = 1'b0;
        send_frame(8'h3C, 1'b1, 1'b0, 1'b1);
        idle(4);
        send_frame(8'hC3, 1'b1, 1'b0, 1'b0);
        exp_ovr++;
        idle(20);
        check("ovr_valid_held", valid_out, 1);
        check("ovr_data_held", data_out, 8'h3C);
        check("ovr_count", seen_ovr, exp_ovr);
        ready_in = 1'b1;
        tick();
        check("ovr_valid_dropped", valid_out, 0);
        idle(10);

        // Reset during bit 4 of a frame (data_out still holds 0x3C).
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0);
        rx = 1'b0;
        repeat (8) tick();
        n_rst = 1'b0;
        tick();
        check_outputs_zero("midframe_reset");
        repeat (3) tick();
        rx    = 1'b1;
        n_rst = 1'b1;
        idle(30);
        send_frame(8'h81, 1'b1, 1'b0, 1'b1);
        idle(20);

        // Disable during bit 4; the rest of the frame must be ignored.
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b0, 1'b0);
        en = 1'b0;
        for (int i = 4; i < DATA_BITS; i++) send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        idle(10);
        en = 1'b1;
        idle(10);

        // Enable rising while the line is low must not start a frame.
        en = 1'b0;
        rx = 1'b0;
        repeat (10) tick();
        en = 1'b1;
        repeat (40) tick();
        idle(20);
        send_frame(8'h96, 1'b1, 1'b0, 1'b1);
        idle(20);

        // Spikes at each bit centre are outvoted.
        send_frame(8'h00, 1'b1, 1'b1, 1'b1);
        idle(20);
        check("spike_data", data_out, 8'h00);

        // Random frames, occasionally with a bad stop bit.
        for (int n = 0; n < 20; n++) begin
            w   = DATA_BITS'($urandom);
            bad = ($urandom_range(0, 5) == 0);
            send_frame(w, !bad, 1'b0, !bad);
            idle(bad ? int'($urandom_range(4, 12)) : int'($urandom_range(0, 12)));
        end
        idle(30);

        check("queue_empty", exp_q.size(), 0);
        check("ferr_total", seen_ferr, exp_ferr);
        check("ovr_total", seen_ovr, exp_ovr);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
